// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Next-PC select codes, reset defaults and fetch FSM encoding.
package fetch_unit_pkg;

   localparam logic [31:0] RESET_VECTOR_DEF = 32'h0040_0000;
   localparam logic [31:0] INST_NOP         = 32'h0000_0013;

   localparam logic [1:0] PC_SEL_PLUS4 = 2'b00;
   localparam logic [1:0] PC_SEL_IMM   = 2'b01;
   localparam logic [1:0] PC_SEL_JALR  = 2'b10;
   localparam logic [1:0] PC_SEL_TRAP  = 2'b11;

   typedef enum logic [1:0] {
      ST_FETCH = 2'b00,
      ST_WAIT  = 2'b01,
      ST_READY = 2'b10,
      ST_FAULT = 2'b11
   } fetch_state_e;

   function automatic logic word_misaligned(
      input logic [1:0] addr_lsb
   );
      return addr_lsb != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_unit_next_pc_mux.sv
// Next-PC selection for the fetch stage.
// Purely combinational; also flags non-word-aligned targets.
module next_pc_mux
   import fetch_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] pc,
   input  logic [1:0]      next_pc_select,
   input  logic [XLEN-1:0] branch_target,
   input  logic [XLEN-1:0] jalr_target,
   input  logic [XLEN-1:0] trap_target,
   output logic [XLEN-1:0] next_pc,
   output logic            misaligned
);

   // pick the successor PC; jalr always drops bit 0
   always_comb begin
      next_pc = pc + XLEN'(4);
      unique case (next_pc_select)
         PC_SEL_PLUS4: next_pc = pc + XLEN'(4);
         PC_SEL_IMM:   next_pc = branch_target;
         PC_SEL_JALR:  next_pc = jalr_target & ~XLEN'(1);
         PC_SEL_TRAP:  next_pc = trap_target;
      endcase
   end

   assign misaligned = word_misaligned(next_pc[1:0]);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory,
// holds one fetched instruction for execute, traps on misaligned PCs.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [1:0]      next_pc_select,
   input  logic [XLEN-1:0] branch_target,
   input  logic [XLEN-1:0] jalr_target,
   input  logic [XLEN-1:0] trap_target,
   input  logic            advance,
   input  logic            trap_redirect,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic            inst_valid,
   output logic [31:0]     inst,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus_4,
   output logic            fetch_misaligned
);

   fetch_state_e    state;
   logic            redirect_pending;
   logic [XLEN-1:0] mux_next_pc;
   logic            mux_misaligned;
   logic            handshake;
   logic            rsp_discard;
   logic            pc_load;
   logic [XLEN-1:0] pc_load_val;

   next_pc_mux #(
      .XLEN(XLEN)
   ) u_next_pc_mux (
      .pc             (pc),
      .next_pc_select (next_pc_select),
      .branch_target  (branch_target),
      .jalr_target    (jalr_target),
      .trap_target    (trap_target),
      .next_pc        (mux_next_pc),
      .misaligned     (mux_misaligned)
   );

   assign imem_req_valid = reset && (state == ST_FETCH);
   assign imem_req_addr  = pc;
   assign handshake      = imem_req_valid && imem_req_ready;
   assign rsp_discard    = redirect_pending || trap_redirect;

   // decide whether and with what the PC is reloaded this cycle
   always_comb begin
      pc_load     = 1'b0;
      pc_load_val = pc;
      unique case (state)
         ST_FETCH: begin
            if (trap_redirect && !imem_req_ready) begin
               pc_load     = 1'b1;
               pc_load_val = trap_target;
            end
         end
         ST_WAIT: begin
            if (imem_rsp_valid && rsp_discard) begin
               pc_load     = 1'b1;
               pc_load_val = trap_target;
            end
         end
         ST_READY: begin
            if (trap_redirect) begin
               pc_load     = 1'b1;
               pc_load_val = trap_target;
            end else if (advance) begin
               pc_load     = 1'b1;
               pc_load_val = mux_next_pc;
            end
         end
         ST_FAULT: begin
            if (trap_redirect) begin
               pc_load     = 1'b1;
               pc_load_val = trap_target;
            end
         end
      endcase
   end

   // PC and its successor move together so pc_plus_4 is never stale
   always_ff @(posedge clock) begin
      if (!reset) begin
         pc        <= RESET_VECTOR;
         pc_plus_4 <= RESET_VECTOR + XLEN'(4);
      end else if (pc_load) begin
         pc        <= pc_load_val;
         pc_plus_4 <= pc_load_val + XLEN'(4);
      end
   end

   // fetch FSM with registered instruction, valid and fault outputs
   always_ff @(posedge clock) begin
      if (!reset) begin
         state            <= ST_FETCH;
         inst_valid       <= 1'b0;
         inst             <= INST_NOP;
         fetch_misaligned <= 1'b0;
         redirect_pending <= 1'b0;
      end else begin
         unique case (state)
            ST_FETCH: begin
               if (handshake) begin
                  state            <= ST_WAIT;
                  redirect_pending <= trap_redirect;
               end
            end
            ST_WAIT: begin
               if (imem_rsp_valid) begin
                  if (rsp_discard) begin
                     redirect_pending <= 1'b0;
                     state            <= ST_FETCH;
                  end else begin
                     inst       <= imem_rsp_data;
                     inst_valid <= 1'b1;
                     state      <= ST_READY;
                  end
               end else if (trap_redirect) begin
                  redirect_pending <= 1'b1;
               end
            end
            ST_READY: begin
               if (trap_redirect) begin
                  inst_valid <= 1'b0;
                  state      <= ST_FETCH;
               end else if (advance) begin
                  inst_valid <= 1'b0;
                  if (mux_misaligned) begin
                     fetch_misaligned <= 1'b1;
                     state            <= ST_FAULT;
                  end else begin
                     state <= ST_FETCH;
                  end
               end
            end
            ST_FAULT: begin
               if (trap_redirect) begin
                  fetch_misaligned <= 1'b0;
                  state            <= ST_FETCH;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: random memory timing and control,
// expected deliveries queued by the driver, popped by a monitor.
module tb_fetch_unit;

   localparam logic [31:0] RV = 32'h0040_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  next_pc_select = 2'b00;
   logic [31:0] branch_target = '0;
   logic [31:0] jalr_target = '0;
   logic [31:0] trap_target = '0;
   logic        advance = 1'b0;
   logic        trap_redirect = 1'b0;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] pc;
   logic [31:0] pc_plus_4;
   logic        fetch_misaligned;

   always #5 clock = ~clock;

   fetch_unit #(
      .XLEN(32),
      .RESET_VECTOR(RV)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .next_pc_select   (next_pc_select),
      .branch_target    (branch_target),
      .jalr_target      (jalr_target),
      .trap_target      (trap_target),
      .advance          (advance),
      .trap_redirect    (trap_redirect),
      .imem_req_valid   (imem_req_valid),
      .imem_req_addr    (imem_req_addr),
      .imem_req_ready   (imem_req_ready),
      .imem_rsp_valid   (imem_rsp_valid),
      .imem_rsp_data    (imem_rsp_data),
      .inst_valid       (inst_valid),
      .inst             (inst),
      .pc               (pc),
      .pc_plus_4        (pc_plus_4),
      .fetch_misaligned (fetch_misaligned)
   );

   int checks = 0;
   int failures = 0;

   task automatic check32(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // memory image: fixed words where the plan needs them, hash elsewhere
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == RV) return 32'h0000_0093;
      if (a == 32'h0000_0200) return 32'hDEAD_BEEF;
      return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
   endfunction

   // architectural next-PC rule
   function automatic logic [31:0] ref_next(input logic [1:0] sel,
      input logic [31:0] cur, input logic [31:0] bt,
      input logic [31:0] jt, input logic [31:0] tt);
      case (sel)
         2'd0: return cur + 32'd4;
         2'd1: return bt;
         2'd2: return jt - (jt % 2);
         default: return tt;
      endcase
   endfunction

   typedef struct packed {
      logic        fault;
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t exp_q[$];

   // memory responder
   bit          fast_mode = 1'b1;
   int          fixed_delay = 0;
   int          stall_left = 0;
   int          rsp_delay = -1;
   logic [31:0] rsp_addr = '0;
   bit          stalling = 1'b0;
   logic [31:0] stall_addr = '0;
   logic        trap_at_edge = 1'b0;

   always @(posedge clock) trap_at_edge = trap_redirect;

   // drive ready/response at each falling edge, check stall stability
   always @(negedge clock) begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (rsp_delay == 0) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(rsp_addr);
         rsp_delay      = -1;
      end else if (rsp_delay > 0) begin
         rsp_delay--;
      end else if (!fast_mode && $urandom_range(0, 7) == 0) begin
         imem_rsp_valid = 1'b1;
      end
      if (reset && stalling && !trap_at_edge) begin
         check32("stall_req_valid", {31'b0, imem_req_valid}, 32'd1);
         check32("stall_addr", imem_req_addr, stall_addr);
      end
      if (stall_left > 0) begin
         imem_req_ready = 1'b0;
         if (imem_req_valid) stall_left--;
      end else if (fast_mode) begin
         imem_req_ready = 1'b1;
      end else begin
         imem_req_ready = ($urandom_range(0, 2) != 0);
      end
      stalling   = imem_req_valid && !imem_req_ready;
      stall_addr = imem_req_addr;
      if (imem_req_valid && imem_req_ready) begin
         rsp_addr  = imem_req_addr;
         rsp_delay = fast_mode ? fixed_delay : $urandom_range(0, 3);
      end
   end

   // monitor: pop an expectation on each new delivery or fault
   logic prev_iv = 1'b0;
   logic prev_fm = 1'b0;
   exp_t mon_e;

   always @(negedge clock) begin
      if (reset) begin
         if ((inst_valid && !prev_iv) || (fetch_misaligned && !prev_fm)) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected: got pc %h, required no event", pc);
            end else begin
               mon_e = exp_q.pop_front();
               check32("sb_fault", {31'b0, fetch_misaligned}, {31'b0, mon_e.fault});
               check32("sb_inst_valid", {31'b0, inst_valid}, {31'b0, !mon_e.fault});
               check32("sb_pc", pc, mon_e.pc);
               check32("sb_pc_plus_4", pc_plus_4, mon_e.pc + 32'd4);
               if (!mon_e.fault) check32("sb_inst", inst, mon_e.inst);
            end
         end
         if (fetch_misaligned)
            check32("fault_no_req", {31'b0, imem_req_valid}, 32'd0);
      end
      prev_iv = inst_valid;
      prev_fm = fetch_misaligned;
   end

   logic [31:0] model_pc = RV;
   bit          model_fault = 1'b0;

   task automatic wait_inst();
      int n;
      n = 0;
      while (n < 300) begin
         @(negedge clock);
         #1;
         if (inst_valid) break;
         advance = (!fast_mode && $urandom_range(0, 3) == 0);
         n++;
      end
      advance = 1'b0;
      if (n >= 300) begin
         checks++;
         failures++;
         $display("FAIL wait_inst: got no inst_valid, required one within 300 cycles");
      end
   endtask

   task automatic do_advance(input logic [1:0] sel, input logic [31:0] bt,
                             input logic [31:0] jt, input logic [31:0] tt);
      logic [31:0] nxt;
      bit          mis;
      exp_t        e;
      wait_inst();
      nxt = ref_next(sel, model_pc, bt, jt, tt);
      mis = (nxt % 4) != 0;
      next_pc_select = sel;
      branch_target  = bt;
      jalr_target    = jt;
      trap_target    = tt;
      advance        = 1'b1;
      @(posedge clock);
      #1;
      advance = 1'b0;
      e.fault = mis;
      e.pc    = nxt;
      e.inst  = mem_word(nxt);
      exp_q.push_back(e);
      if (mis) begin
         check32("adv_fault_flag", {31'b0, fetch_misaligned}, 32'd1);
         check32("adv_fault_no_req", {31'b0, imem_req_valid}, 32'd0);
      end else begin
         check32("adv_req_valid", {31'b0, imem_req_valid}, 32'd1);
         check32("adv_req_addr", imem_req_addr, nxt);
      end
      model_pc    = nxt;
      model_fault = mis;
   endtask

   task automatic do_trap(input logic [31:0] tt, input bit with_adv);
      bit   immediate;
      exp_t e;
      @(negedge clock);
      #1;
      immediate = (exp_q.size() == 0);
      if (!immediate) void'(exp_q.pop_back());
      trap_target    = tt;
      trap_redirect  = 1'b1;
      advance        = with_adv;
      next_pc_select = 2'($urandom_range(0, 3));
      e.fault = 1'b0;
      e.pc    = tt;
      e.inst  = mem_word(tt);
      exp_q.push_back(e);
      @(posedge clock);
      #1;
      trap_redirect = 1'b0;
      advance       = 1'b0;
      if (immediate) begin
         check32("trap_fault_clr", {31'b0, fetch_misaligned}, 32'd0);
         check32("trap_inst_valid", {31'b0, inst_valid}, 32'd0);
         check32("trap_req_valid", {31'b0, imem_req_valid}, 32'd1);
         check32("trap_req_addr", imem_req_addr, tt);
      end
      model_pc    = tt;
      model_fault = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int          cnt;
      logic [31:0] bt, jt, tt;
      exp_t        e0;
      int          r;

      repeat (3) @(negedge clock);
      #1;
      check32("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      check32("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      check32("rst_inst", inst, 32'h0000_0013);
      check32("rst_pc", pc, RV);
      check32("rst_pc_plus_4", pc_plus_4, RV + 32'd4);
      check32("rst_fault", {31'b0, fetch_misaligned}, 32'd0);

      e0.fault = 1'b0;
      e0.pc    = RV;
      e0.inst  = 32'h0000_0093;
      exp_q.push_back(e0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      check32("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
      check32("first_req_addr", imem_req_addr, RV);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clock);
         cnt++;
         @(negedge clock);
         #1;
         if (inst_valid) break;
      end
      check32("first_latency", cnt, 32'd2);

      do_advance(2'b01, 32'h0040_0020, 32'h0, 32'h0);
      wait_inst();
      do_trap(RV, 1'b0);
      wait_inst();
      do_advance(2'b00, 32'h0040_0020, 32'h0, 32'h0);
      do_advance(2'b10, 32'h0, 32'h0040_0101, 32'h0);
      do_advance(2'b10, 32'h0, 32'h0040_0102, 32'h0);
      do_trap(32'h0000_0100, 1'b0);

      fixed_delay = 3;
      do_advance(2'b01, 32'h0000_0200, 32'h0, 32'h0);
      @(posedge clock);
      do_trap(32'h0000_0300, 1'b0);
      wait_inst();
      fixed_delay = 0;

      do_trap(32'hFFFF_FFFC, 1'b0);
      do_advance(2'b00, 32'h0, 32'h0, 32'h0);

      wait_inst();
      stall_left = 5;
      do_trap(32'h0000_1000, 1'b1);

      fast_mode = 1'b0;
      for (int k = 0; k < 400; k++) begin
         tt = $urandom & 32'hFFFF_FFFC;
         if (model_fault) begin
            do_trap(tt, 1'($urandom_range(0, 1)));
         end else begin
            r = $urandom_range(0, 9);
            if (r < 8) begin
               bt = $urandom & 32'hFFFF_FFFC;
               if ($urandom_range(0, 7) == 0) bt[1:0] = 2'($urandom_range(1, 3));
               jt = $urandom & 32'hFFFF_FFFD;
               if ($urandom_range(0, 7) == 0) jt[1] = 1'b1;
               do_advance(2'($urandom_range(0, 3)), bt, jt, tt);
            end else if (r == 8) begin
               repeat ($urandom_range(0, 3)) @(posedge clock);
               do_trap(tt, 1'($urandom_range(0, 1)));
            end else begin
               wait_inst();
               do_trap(tt, 1'($urandom_range(0, 1)));
            end
         end
      end

      for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clock);
      check32("sb_drained", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
